// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO responder and its storage array.
package fifo_pkg;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned DEPTH_DEF    = 8;
  localparam int unsigned ADDR_W_DEF   = $clog2(DEPTH_DEF);
  localparam int unsigned CNT_W_DEF    = $clog2(DEPTH_DEF + 1);
  localparam int unsigned AF_LEVEL_DEF = 6;
  localparam int unsigned AE_LEVEL_DEF = 2;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array with one write port and one registered read port.
module fifo_mem #(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W_DEF,
  parameter int unsigned DEPTH  = fifo_pkg::DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_resp.sv
// Single-clock FIFO responder: pointers, occupancy count, status decode and
// one-cycle overrun/underrun pulses around a registered-read storage array.
module sync_fifo_resp
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AF_LEVEL = AF_LEVEL_DEF,
  parameter int unsigned AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_enb,
  input  logic              rd_enb,
  output logic [DATA_W-1:0] rd_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic              fifo_overrun,
  output logic              fifo_underrun
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overrun_q, underrun_q;
  logic              push_ok, pop_ok;

  assign push_ok = wr_enb & ~fifo_full;
  assign pop_ok  = rd_enb & ~fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    // Count moves only when exactly one side is accepted.
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= wr_enb & fifo_full;
      underrun_q <= rd_enb & fifo_empty;
    end
  end

  assign fifo_full         = (count_q == CNT_W'(DEPTH));
  assign fifo_empty        = (count_q == '0);
  assign fifo_almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign fifo_almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign fifo_overrun      = overrun_q;
  assign fifo_underrun     = underrun_q;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (pop_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_resp.sv
// Directed bench for sync_fifo_resp: queue-based reference checked every cycle
// plus literal expectations at the key protocol points.
module tb_sync_fifo_resp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_enb = 1'b1;
  logic       rd_enb = 1'b1;
  logic [7:0] rd_data;
  logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic       fifo_overrun, fifo_underrun;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  sync_fifo_resp #(
    .DATA_W   (8),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .wr_data           (wr_data),
    .wr_enb            (wr_enb),
    .rd_enb            (rd_enb),
    .rd_data           (rd_data),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_overrun      (fifo_overrun),
    .fifo_underrun     (fifo_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a queue of stored words plus the last popped word.
  int         mq[$];
  logic [7:0] m_rd = '0;
  logic       m_ov = 1'b0, m_un = 1'b0;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    int sz;
    bit was_full, was_empty;
    sz = mq.size();
    was_full  = (sz == 8);
    was_empty = (sz == 0);
    if (rst) begin
      mq.delete();
      m_rd = '0; m_ov = 1'b0; m_un = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_ov = wr_enb && was_full;
      m_un = rd_enb && was_empty;
      if (rd_enb && !was_empty) m_rd = 8'(mq.pop_front());
      if (wr_enb && !was_full) mq.push_back(int'(wr_data));
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("rd_data",      {24'b0, rd_data},            {24'b0, m_rd});
      chk("full",         {31'b0, fifo_full},          {31'b0, mq.size() == 8});
      chk("empty",        {31'b0, fifo_empty},         {31'b0, mq.size() == 0});
      chk("almost_full",  {31'b0, fifo_almost_full},   {31'b0, mq.size() >= 6});
      chk("almost_empty", {31'b0, fifo_almost_empty},  {31'b0, mq.size() <= 2});
      chk("overrun",      {31'b0, fifo_overrun},       {31'b0, m_ov});
      chk("underrun",     {31'b0, fifo_underrun},      {31'b0, m_un});
    end
  end

  // Present one cycle of stimulus, consume it on the next edge, settle.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_enb = w; wr_data = d; rd_enb = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // 1: reset with both enables high
    step(1'b1, 8'h99, 1'b1);
    step(1'b1, 8'h99, 1'b1);
    chk("rst_empty", {31'b0, fifo_empty}, 32'd1);
    chk("rst_ae",    {31'b0, fifo_almost_empty}, 32'd1);
    chk("rst_full",  {31'b0, fifo_full}, 32'd0);
    chk("rst_rd",    {24'b0, rd_data}, 32'h00);
    chk("rst_ov",    {31'b0, fifo_overrun}, 32'd0);
    chk("rst_un",    {31'b0, fifo_underrun}, 32'd0);
    rst = 1'b0;

    // 2: single push then pop
    step(1'b1, 8'hAA, 1'b0);
    chk("t2_not_empty", {31'b0, fifo_empty}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_rd", {24'b0, rd_data}, 32'hAA);
    chk("t2_empty", {31'b0, fifo_empty}, 32'd1);
    step(1'b0, 8'h00, 1'b0);

    // 3: fill to full, then overrun
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 4) chk("t3_af_at5", {31'b0, fifo_almost_full}, 32'd0);
      if (i == 5) chk("t3_af_at6", {31'b0, fifo_almost_full}, 32'd1);
      if (i == 6) chk("t3_full_at7", {31'b0, fifo_full}, 32'd0);
    end
    chk("t3_full", {31'b0, fifo_full}, 32'd1);
    step(1'b1, 8'h55, 1'b0);
    chk("t3_ov", {31'b0, fifo_overrun}, 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("t3_ov_pulse", {31'b0, fifo_overrun}, 32'd0);

    // 4: drain in order, then underrun
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("t4_rd", {24'b0, rd_data}, 32'h10 + i);
    end
    chk("t4_empty", {31'b0, fifo_empty}, 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_un", {31'b0, fifo_underrun}, 32'd1);
    chk("t4_rd_hold", {24'b0, rd_data}, 32'h17);
    step(1'b0, 8'h00, 1'b0);
    chk("t4_un_pulse", {31'b0, fifo_underrun}, 32'd0);

    // 5: steady-state push+pop at count 4, pointers wrap
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b1);
      chk("t5_rd", {24'b0, rd_data}, (i < 4) ? 32'h20 + i : 32'h30 + i - 4);
      chk("t5_mid", {30'b0, fifo_full, fifo_empty}, 32'd0);
    end

    // 6: fill to full, push+pop while full, then reset mid-burst
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    chk("t6_full", {31'b0, fifo_full}, 32'd1);
    step(1'b1, 8'h50, 1'b1);
    chk("t6_rd", {24'b0, rd_data}, 32'h36);
    chk("t6_ov", {31'b0, fifo_overrun}, 32'd1);
    chk("t6_full_off", {31'b0, fifo_full}, 32'd0);
    step(1'b1, 8'h51, 1'b1);
    rst = 1'b1;
    step(1'b1, 8'h52, 1'b1);
    chk("t6_rst_empty", {31'b0, fifo_empty}, 32'd1);
    chk("t6_rst_rd",    {24'b0, rd_data}, 32'h00);
    chk("t6_rst_af",    {31'b0, fifo_almost_full}, 32'd0);
    chk("t6_rst_ov",    {30'b0, fifo_overrun, fifo_underrun}, 32'd0);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
